// File: rtl/fabric_ram_slave_if.sv
// Request/response bus between a fabric master and the RAM slave, plus the
// architecture package that supplies the default attribute width.
package carbon_arch_pkg;
    localparam int CARBON_FABRIC_ATTR_WIDTH_BITS = 4;
endpackage

interface fabric_ram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int OP_W   = 8,
    parameter int SIZE_W = 3,
    parameter int ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic [SIZE_W-1:0]   req_size;
    logic [ATTR_W-1:0]   req_attr;
    logic [ID_W-1:0]     req_id;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [CODE_W-1:0]   rsp_code;
    logic [ID_W-1:0]     rsp_id;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_code, rsp_id,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_code, rsp_id,
        output rsp_ready
    );
endinterface

// File: rtl/fabric_ram_slave.sv
// Single-port RAM behind a valid/ready fabric port: one-cycle synchronous
// access, one in-flight slot and a 2-entry response FIFO.
module fabric_ram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int OP_W        = 8,
    parameter int SIZE_W      = 3,
    parameter int ATTR_W      = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W      = 8,
    parameter int DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic clk,
    input logic rst,
    fabric_ram_slave_if.slave bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);

    localparam logic [OP_W-1:0]   OP_READ     = OP_W'(8'h00);
    localparam logic [OP_W-1:0]   OP_WRITE    = OP_W'(8'h01);
    localparam logic [CODE_W-1:0] RC_OK       = CODE_W'(8'h00);
    localparam logic [CODE_W-1:0] RC_UNSUP    = CODE_W'(8'h01);
    localparam logic [CODE_W-1:0] RC_DECERR   = CODE_W'(8'h02);
    localparam logic [CODE_W-1:0] RC_MISALIGN = CODE_W'(8'h03);
    localparam logic [SIZE_W-1:0] MAX_SIZE    = SIZE_W'(LANE_W);
    localparam logic [ADDR_W:0]   RAM_BYTES   = (ADDR_W+1)'(DEPTH_WORDS * NBYTES);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [CODE_W-1:0] code;
        logic [ID_W-1:0]   id;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_q;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] align_mask;
    logic [IDX_W-1:0]  widx;
    logic [CODE_W-1:0] code;
    logic              accept, wr_en, rd_en;

    logic              slot_vld, slot_rd;
    logic [CODE_W-1:0] slot_code;
    logic [ID_W-1:0]   slot_id;

    rsp_t       fifo_q [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] fifo_count;
    logic [2:0] occ;
    logic       fifo_nonempty, push, pop, ready;
    rsp_t       head;

    logic unused_attr;
    assign unused_attr = ^bus.req_attr;

    // Request decode, in error priority order.
    always_comb begin
        off        = bus.req_addr - BASE_ADDR;
        align_mask = (ADDR_W'(1) << bus.req_size) - ADDR_W'(1);
        widx       = off[LANE_W +: IDX_W];
        code       = RC_OK;
        if (bus.req_op != OP_READ && bus.req_op != OP_WRITE)
            code = RC_UNSUP;
        else if (bus.req_size > MAX_SIZE)
            code = RC_UNSUP;
        else if ((off & align_mask) != '0)
            code = RC_MISALIGN;
        else if ({1'b0, off} >= RAM_BYTES)
            code = RC_DECERR;
    end

    // Credit check only looks at local occupancy, never at the request itself.
    always_comb begin
        occ           = {1'b0, fifo_count} + {2'b00, slot_vld};
        fifo_nonempty = !rst && (fifo_count != 2'd0);
        pop           = fifo_nonempty && bus.rsp_ready;
        ready         = !rst && ((occ < 3'd2) || (occ == 3'd2 && pop));
        accept        = bus.req_valid && ready;
        wr_en         = accept && bus.req_op == OP_WRITE && code == RC_OK;
        rd_en         = accept && bus.req_op == OP_READ  && code == RC_OK;
        push          = slot_vld;
        head          = fifo_q[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.req_wstrb[b])
                    mem[widx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
        if (rd_en)
            rd_q <= mem[widx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= 1'b0;
            slot_rd    <= 1'b0;
            slot_code  <= '0;
            slot_id    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            slot_vld <= accept;
            if (accept) begin
                slot_code <= code;
                slot_id   <= bus.req_id;
                slot_rd   <= rd_en;
            end
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Only read responses carry data; rd_q is valid exactly in the slot cycle.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{rdata: slot_rd ? rd_q : '0, code: slot_code, id: slot_id};
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = fifo_nonempty;
    assign bus.rsp_rdata = fifo_nonempty ? head.rdata : '0;
    assign bus.rsp_code  = fifo_nonempty ? head.code  : '0;
    assign bus.rsp_id    = fifo_nonempty ? head.id    : '0;
endmodule

// File: tb/tb_fabric_ram_slave.sv
// Randomized bench for fabric_ram_slave with a byte-level reference model and
// an in-order response scoreboard.
module tb_fabric_ram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fabric_ram_slave_if bus();
    fabric_ram_slave dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  code;
        logic [3:0]  id;
    } exp_t;

    int checks = 0;
    int failures = 0;
    exp_t exp_q [$];
    logic [31:0] mdl_mem [1024];
    int cyc = 0;
    int pop_cyc [$];
    int acc_cyc [$];
    logic [31:0] last_rdata;
    logic [7:0]  last_code;
    logic [3:0]  last_id;
    logic        bp_rand = 1'b0;
    logic        rdy_force = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        bus.rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Monitor + reference model, sampled mid-cycle.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_rdata;
    logic [7:0]  prev_code;
    logic [3:0]  prev_id;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", bus.rsp_valid, 1'b1);
                chk("hold_rdata", bus.rsp_rdata, prev_rdata);
                chk("hold_code", bus.rsp_code, prev_code);
                chk("hold_id", bus.rsp_id, prev_id);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_code", bus.rsp_code, e.code);
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                end
                pop_cyc.push_back(cyc);
                last_rdata = bus.rsp_rdata;
                last_code  = bus.rsp_code;
                last_id    = bus.rsp_id;
            end
            hold_prev  = bus.rsp_valid && !bus.rsp_ready;
            prev_rdata = bus.rsp_rdata;
            prev_code  = bus.rsp_code;
            prev_id    = bus.rsp_id;
            if (bus.req_valid && bus.req_ready) begin
                exp_t e;
                logic [31:0] off;
                off     = bus.req_addr;
                e.id    = bus.req_id;
                e.rdata = 32'h0;
                if (bus.req_op > 8'h01)                          e.code = 8'h01;
                else if (bus.req_size > 3'd2)                    e.code = 8'h01;
                else if (off % (32'd1 << bus.req_size) != 32'd0) e.code = 8'h03;
                else if (off >= 32'd4096)                        e.code = 8'h02;
                else                                             e.code = 8'h00;
                if (e.code == 8'h00) begin
                    if (bus.req_op == 8'h01) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.req_wstrb[b]) mdl_mem[off/4][8*b +: 8] = bus.req_wdata[8*b +: 8];
                    end else begin
                        e.rdata = mdl_mem[off/4];
                    end
                end
                exp_q.push_back(e);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] sz, input logic [3:0] id);
        bit done;
        done = 1'b0;
        bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_wstrb = st; bus.req_size = sz; bus.req_id = id;
        bus.req_attr = 4'($urandom);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("req_accepted", done, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !bus.rsp_valid) break;
            step(1);
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, p0, a0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_wstrb = '0; bus.req_size = '0; bus.req_attr = '0; bus.req_id = '0;
        step(3);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_code", bus.rsp_code, 8'h0);
        chk("rst_rsp_id", bus.rsp_id, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_ready", bus.req_ready, 1'b1);
        step(1);

        for (int w = 0; w < 64; w++) send(8'h01, 32'(w * 4), $urandom, 4'hF, 3'd2, 4'(w));
        drain();

        send(8'h01, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd5);
        drain();
        chk("wr_rd_rdata", last_rdata, 32'hDEADBEEF);
        chk("wr_rd_id", last_id, 4'd5);

        send(8'h01, 32'h10, 32'h11223344, 4'h2, 3'd2, 4'd1);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd2);
        drain();
        chk("strb_rdata", last_rdata, 32'hDEAD33EF);

        send(8'h07, 32'h10, 32'h0, 4'h0, 3'd2, 4'd6);
        drain(); chk("err_op", last_code, 8'h01);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd3, 4'd7);
        drain(); chk("err_size", last_code, 8'h01);
        send(8'h00, 32'h02, 32'h0, 4'h0, 3'd2, 4'd8);
        drain(); chk("err_misalign", last_code, 8'h03);
        send(8'h00, 32'h1000, 32'h0, 4'h0, 3'd2, 4'd9);
        drain(); chk("err_decerr", last_code, 8'h02);
        chk("err_rdata", last_rdata, 32'h0);
        send(8'h01, 32'h12, 32'hFFFFFFFF, 4'hF, 3'd2, 4'd10);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd11);
        drain(); chk("err_no_write", last_rdata, 32'hDEAD33EF);

        // Backpressure: only two requests fit with the response side stalled.
        rdy_force = 1'b0;
        step(1);
        acc = 0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_op = 8'h00; bus.req_addr = 32'(acc * 4); bus.req_size = 3'd2;
            bus.req_id = 4'(acc); bus.req_wstrb = 4'h0;
            @(negedge clk);
            if (bus.req_ready) acc++;
            step(1);
        end
        chk("bp_accepted", acc, 2);
        chk("bp_ready_low", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        rdy_force = 1'b1;
        send(8'h00, 32'h08, 32'h0, 4'h0, 3'd2, 4'd2);
        send(8'h00, 32'h0C, 32'h0, 4'h0, 3'd2, 4'd3);
        drain();
        chk("bp_last_id", last_id, 4'd3);

        p0 = pop_cyc.size();
        a0 = acc_cyc.size();
        for (int i = 0; i < 16; i++) send(8'h00, 32'(i * 4), 32'h0, 4'h0, 3'd2, 4'(i));
        drain();
        chk("burst_pops", pop_cyc.size() - p0, 16);
        chk("burst_accs", acc_cyc.size() - a0, 16);
        if (pop_cyc.size() - p0 == 16 && acc_cyc.size() - a0 == 16) begin
            chk("burst_ready_cont", acc_cyc[a0+15] - acc_cyc[a0], 15);
            chk("burst_rsp_cont", pop_cyc[p0+15] - pop_cyc[p0], 15);
            chk("burst_latency", (pop_cyc[p0] - acc_cyc[a0]) inside {[1:2]}, 1'b1);
        end

        // Reset with two responses buffered.
        rdy_force = 1'b0;
        step(1);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd12);
        send(8'h00, 32'h14, 32'h0, 4'h0, 3'd2, 4'd13);
        step(2);
        chk("pre_rst_valid", bus.rsp_valid, 1'b1);
        p0 = pop_cyc.size();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b0);
        step(1);
        rst = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", bus.rsp_valid, 1'b0);
        chk("post_rst_ready", bus.req_ready, 1'b1);
        step(5);
        chk("no_stale_rsp", pop_cyc.size() - p0, 0);
        send(8'h00, 32'h10, 32'h0, 4'h0, 3'd2, 4'd14);
        drain();
        chk("ram_kept", last_rdata, 32'hDEAD33EF);

        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            logic [2:0]  sz;
            op   = ($urandom_range(0, 9) == 0) ? 8'h07 : 8'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255))
                                               : 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 9) == 0) addr = addr + 32'h1000;
            send(op, addr, $urandom, 4'($urandom), sz, 4'($urandom));
        end
        bp_rand = 1'b0;
        rdy_force = 1'b1;
        step(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
